// File: rtl/alu_seq_pkg.sv
// Shared types, widths and helpers for the ALU command sequencer.
package alu_seq_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    AND  = 3'b010,
    OR   = 3'b011,
    XOR  = 3'b100,
    NOTB = 3'b101,
    INCB = 3'b110,
    ASRB = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } seq_state_t;

  // Only the arithmetic ops produce a meaningful carry/overflow from the ALU.
  function automatic logic v_valid(alu_op_t op);
    return (op == ADD) || (op == SUB) || (op == INCB);
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// Small register file: NREGS x DATA_W, two combinational read ports,
// one synchronous write port, asynchronous clear.
module seq_regfile
  import alu_seq_pkg::*;
#(
  parameter  int NREGS = 4,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   ra_idx,
  input  logic [RA_W-1:0]   rb_idx,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [RA_W-1:0]   wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREGS];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        q_reg <= '0;
      end else if (we && (wr_idx == RA_W'(gi))) begin
        q_reg <= wr_data;
      end
    end

    assign regs[gi] = q_reg;
  end

  assign ra_data = regs[ra_idx];
  assign rb_data = regs[rb_idx];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side controller for the external 4-bit combinational ALU.
// Optional sticky overflow flag (ports ovf_sticky/ovf_clr) under ALU_SEQ_STICKY_OVF_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter  int NREGS = 4,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_load,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [RA_W-1:0]   cmd_rd,
  input  logic [RA_W-1:0]   cmd_ra,
  input  logic [RA_W-1:0]   cmd_rb,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_s,
  input  logic [DATA_W-1:0] alu_e,
  input  logic              alu_z,
  input  logic              alu_v,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_z,
  output logic              rsp_v,
  output logic [RA_W-1:0]   rsp_rd
`ifdef ALU_SEQ_STICKY_OVF_EN
  ,
  output logic              ovf_sticky,
  input  logic              ovf_clr
`endif
);

  typedef struct packed {
    alu_op_t           op;
    logic              load;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   ra;
    logic [RA_W-1:0]   rb;
  } cmd_t;

  seq_state_t        state_reg, state_next;
  cmd_t              cmd_reg;
  logic              accept, issue_en, capture_en;
  logic [DATA_W-1:0] ra_data, rb_data;
  logic [DATA_W-1:0] cap_data;
  logic              cap_z, cap_v;

  seq_regfile #(.NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_idx  (cmd_reg.ra),
    .rb_idx  (cmd_reg.rb),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (capture_en),
    .wr_idx  (cmd_reg.rd),
    .wr_data (cap_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // cmd_ready is forced low while reset is held even though the state already reads IDLE.
  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    issue_en   = 1'b0;
    capture_en = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid && !reset) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        issue_en   = 1'b1;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        capture_en = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Loads bypass the ALU entirely; V is only trusted for arithmetic ops.
  always_comb begin
    cap_data = cmd_reg.load ? cmd_reg.imm : alu_e;
    cap_z    = cmd_reg.load ? (cmd_reg.imm == '0) : alu_z;
    cap_v    = !cmd_reg.load && v_valid(cmd_reg.op) && alu_v;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_reg  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_s    <= '0;
      rsp_data <= '0;
      rsp_z    <= 1'b0;
      rsp_v    <= 1'b0;
      rsp_rd   <= '0;
    end else begin
      if (accept) begin
        cmd_reg.op     <= alu_op_t'(cmd_op);
        cmd_reg.load   <= cmd_load;
        cmd_reg.imm_en <= cmd_imm_en;
        cmd_reg.imm    <= cmd_imm;
        cmd_reg.rd     <= cmd_rd;
        cmd_reg.ra     <= cmd_ra;
        cmd_reg.rb     <= cmd_rb;
      end
      if (issue_en) begin
        alu_a <= ra_data;
        alu_b <= cmd_reg.imm_en ? cmd_reg.imm : rb_data;
        alu_s <= cmd_reg.op;
      end
      if (capture_en) begin
        rsp_data <= cap_data;
        rsp_z    <= cap_z;
        rsp_v    <= cap_v;
        rsp_rd   <= cmd_reg.rd;
      end
    end
  end

`ifdef ALU_SEQ_STICKY_OVF_EN
  logic ovf_sticky_reg;

  // A new overflow in CAPTURE takes priority over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_sticky_reg <= 1'b0;
    end else if (capture_en && cap_v) begin
      ovf_sticky_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_reg <= 1'b0;
    end
  end

  assign ovf_sticky = ovf_sticky_reg;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed table, hand-written
// reset/sticky sequences, and randomized commands against a reference model.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_load, cmd_imm_en;
  logic [3:0] cmd_imm;
  logic [1:0] cmd_rd, cmd_ra, cmd_rb;
  logic [3:0] alu_a, alu_b, alu_e;
  logic [2:0] alu_s;
  logic       alu_z, alu_v;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_z, rsp_v;
  logic [1:0] rsp_rd;
`ifdef ALU_SEQ_STICKY_OVF_EN
  logic       ovf_sticky, ovf_clr;
`endif

  int checks = 0;
  int errors = 0;
  int mregs[4];

  typedef struct {
    int op, ld, ie, imm, rd, ra, rb, hold, d, z, v;
  } vec_t;
  vec_t vecs[16];

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_load   (cmd_load),
    .cmd_imm_en (cmd_imm_en),
    .cmd_imm    (cmd_imm),
    .cmd_rd     (cmd_rd),
    .cmd_ra     (cmd_ra),
    .cmd_rb     (cmd_rb),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_e      (alu_e),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_z      (rsp_z),
    .rsp_v      (rsp_v),
    .rsp_rd     (rsp_rd)
`ifdef ALU_SEQ_STICKY_OVF_EN
    ,
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
`endif
  );

  // External combinational ALU; V is deliberately 1 for non-arithmetic ops.
  always_comb begin
    alu_e = 4'h0;
    alu_v = 1'b0;
    case (alu_s)
      3'd0: {alu_v, alu_e} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_v, alu_e} = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      3'd2: begin alu_e = alu_a & alu_b; alu_v = 1'b1; end
      3'd3: begin alu_e = alu_a | alu_b; alu_v = 1'b1; end
      3'd4: begin alu_e = alu_a ^ alu_b; alu_v = 1'b1; end
      3'd5: begin alu_e = ~alu_b; alu_v = 1'b1; end
      3'd6: {alu_v, alu_e} = {1'b0, alu_b} + 5'd1;
      default: begin alu_e = {alu_b[3], alu_b[3:1]}; alu_v = 1'b1; end
    endcase
  end
  assign alu_z = (alu_e == 4'h0);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: integer arithmetic on the architectural register array.
  function automatic void ref_exec(input int op, input int ld, input int ie, input int imm,
                                   input int ra, input int rb,
                                   output int d, output int z, output int v);
    int a, b;
    a = mregs[ra];
    b = ie ? imm : mregs[rb];
    v = 0;
    if (ld) begin
      d = imm;
    end else begin
      case (op)
        0: begin d = (a + b) % 16; v = (a + b > 15) ? 1 : 0; end
        1: begin d = (a - b + 16) % 16; v = (a >= b) ? 1 : 0; end
        2: d = a & b;
        3: d = a | b;
        4: d = a ^ b;
        5: d = 15 - b;
        6: begin d = (b + 1) % 16; v = (b == 15) ? 1 : 0; end
        default: d = b / 2 + ((b >= 8) ? 8 : 0);
      endcase
    end
    z = (d == 0) ? 1 : 0;
  endfunction

  // Present a command and wait for its handshake; returns one cycle into ISSUE.
  task automatic send_cmd(input int op, input int ld, input int ie, input int imm,
                          input int rd, input int ra, input int rb);
    int n;
    n = 0;
    cmd_op     = 3'(op);
    cmd_load   = 1'(ld);
    cmd_imm_en = 1'(ie);
    cmd_imm    = 4'(imm);
    cmd_rd     = 2'(rd);
    cmd_ra     = 2'(ra);
    cmd_rb     = 2'(rb);
    cmd_valid  = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_op     = 3'($urandom);
    cmd_load   = 1'($urandom);
    cmd_imm_en = 1'($urandom);
    cmd_imm    = 4'($urandom);
    cmd_rd     = 2'($urandom);
    cmd_ra     = 2'($urandom);
    cmd_rb     = 2'($urandom);
  endtask

  // start_n is the cycle index (handshake cycle = 0) at which this task is entered.
  task automatic wait_rsp(input int start_n, input int hold, input int ed, input int ez,
                          input int ev, input int erd, input string tag);
    int n;
    n = start_n;
    while (!rsp_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'd3);
    check({tag, ":data"}, 32'(rsp_data), 32'(ed));
    check({tag, ":z"}, 32'(rsp_z), 32'(ez));
    check({tag, ":v"}, 32'(rsp_v), 32'(ev));
    check({tag, ":rd"}, 32'(rsp_rd), 32'(erd));
    if (hold > 0) rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ":hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
      check({tag, ":hold_rsp"}, {23'd0, rsp_data, rsp_z, rsp_v, rsp_rd},
            {23'd0, 4'(ed), 1'(ez), 1'(ev), 2'(erd)});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ":pop_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ":idle_ready"}, 32'(cmd_ready), 32'd1);
    $display("txn %s -> data=%h z=%0d v=%0d rd=%0d lat=%0d hold=%0d",
             tag, rsp_data, rsp_z, rsp_v, rsp_rd, n, hold);
  endtask

  task automatic do_model(input int op, input int ld, input int ie, input int imm,
                          input int rd, input int ra, input int rb, input int hold,
                          input string tag);
    int d, z, v;
    ref_exec(op, ld, ie, imm, ra, rb, d, z, v);
    mregs[rd] = d;
    send_cmd(op, ld, ie, imm, rd, ra, rb);
    wait_rsp(1, hold, d, z, v, rd, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            op ld ie imm rd ra rb hold  d  z  v
    vecs[0]  = '{0, 1, 0,  5, 1, 0, 0, 0,  5, 0, 0};
    vecs[1]  = '{0, 1, 0, 13, 2, 0, 0, 0, 13, 0, 0};
    vecs[2]  = '{0, 0, 0,  0, 3, 1, 2, 0,  2, 0, 1};
    vecs[3]  = '{1, 0, 0,  0, 0, 1, 1, 0,  0, 1, 1};
    vecs[4]  = '{2, 0, 1, 13, 0, 1, 0, 0,  5, 0, 0};
    vecs[5]  = '{0, 1, 0, 13, 2, 0, 0, 0, 13, 0, 0};
    vecs[6]  = '{7, 0, 0,  0, 3, 0, 2, 0, 14, 0, 0};
    vecs[7]  = '{6, 0, 1, 15, 3, 0, 0, 0,  0, 1, 1};
    vecs[8]  = '{0, 1, 0,  9, 1, 0, 0, 0,  9, 0, 0};
    vecs[9]  = '{4, 0, 1, 15, 2, 1, 0, 5,  6, 0, 0};
    vecs[10] = '{3, 0, 0,  0, 0, 2, 1, 0, 15, 0, 0};
    vecs[11] = '{5, 0, 0,  0, 3, 0, 3, 0, 15, 0, 0};
    vecs[12] = '{1, 0, 0,  0, 1, 2, 0, 0,  7, 0, 0};
    vecs[13] = '{0, 1, 0,  0, 3, 0, 0, 0,  0, 1, 0};
    vecs[14] = '{0, 0, 0,  0, 2, 3, 3, 0,  0, 1, 0};
    vecs[15] = '{0, 0, 0,  0, 0, 0, 0, 0, 14, 0, 1};

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 3'd0;
    cmd_load   = 1'b0;
    cmd_imm_en = 1'b0;
    cmd_imm    = 4'd0;
    cmd_rd     = 2'd0;
    cmd_ra     = 2'd0;
    cmd_rb     = 2'd0;
    rsp_ready  = 1'b1;
`ifdef ALU_SEQ_STICKY_OVF_EN
    ovf_clr    = 1'b0;
`endif
    repeat (3) begin @(posedge clk); #1; end
    check("reset:cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset:rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset:rsp", {23'd0, rsp_data, rsp_z, rsp_v, rsp_rd}, 32'd0);
    check("reset:alu", {21'd0, alu_a, alu_b, alu_s}, 32'd0);
    reset = 1'b0;
    #1;
    check("reset_release:cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      send_cmd(vecs[i].op, vecs[i].ld, vecs[i].ie, vecs[i].imm,
               vecs[i].rd, vecs[i].ra, vecs[i].rb);
      wait_rsp(1, vecs[i].hold, vecs[i].d, vecs[i].z, vecs[i].v, vecs[i].rd,
               $sformatf("dir%0d", i));
    end

    // Reset during CAPTURE of a load R1 = 7: command discarded.
    send_cmd(0, 1, 0, 7, 1, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst:rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst:cmd_ready", 32'(cmd_ready), 32'd0);
    check("midrst:alu", {21'd0, alu_a, alu_b, alu_s}, 32'd0);
    check("midrst:rsp_data", 32'(rsp_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_release:cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    check("midrst_after:rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    do_model(3, 0, 0, 0, 0, 1, 1, 0, "midrst_r1_read");

`ifdef ALU_SEQ_STICKY_OVF_EN
    begin
      int d, z, v;
      check("sticky:init", 32'(ovf_sticky), 32'd0);
      do_model(0, 1, 0, 8, 0, 0, 0, 0, "sticky_load8");
      do_model(0, 0, 1, 8, 1, 0, 0, 0, "sticky_add8_8");
      check("sticky:after_add", 32'(ovf_sticky), 32'd1);
      do_model(2, 0, 0, 0, 2, 0, 0, 0, "sticky_and");
      check("sticky:after_and", 32'(ovf_sticky), 32'd1);
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      check("sticky:cleared", 32'(ovf_sticky), 32'd0);
      ref_exec(6, 0, 1, 15, 0, 0, d, z, v);
      mregs[3] = d;
      send_cmd(6, 0, 1, 15, 3, 0, 0);
      @(posedge clk); #1;
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      check("sticky:set_wins", 32'(ovf_sticky), 32'd1);
      wait_rsp(3, 0, d, z, v, 3, "sticky_incF_clr");
    end
`endif

    for (int t = 0; t < 150; t++) begin
      int op, ld, ie, imm, rd, ra, rb, hold, gap;
      op   = int'($urandom_range(0, 7));
      ld   = ($urandom_range(0, 4) == 0) ? 1 : 0;
      ie   = int'($urandom_range(0, 1));
      imm  = int'($urandom_range(0, 15));
      rd   = int'($urandom_range(0, 3));
      ra   = int'($urandom_range(0, 3));
      rb   = int'($urandom_range(0, 3));
      hold = int'($urandom_range(0, 3));
      gap  = int'($urandom_range(0, 2));
      rsp_ready = 1'($urandom);
      repeat (gap) begin @(posedge clk); #1; end
      rsp_ready = 1'b1;
      do_model(op, ld, ie, imm, rd, ra, rb, hold,
               $sformatf("rnd%0d op=%0d ld=%0d ie=%0d imm=%h rd=%0d ra=%0d rb=%0d",
                         t, op, ld, ie, imm, rd, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
